// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : End-of-execute branch resolution. Evaluates the MIPS branch
//               condition on the forwarded operands and compares the outcome
//               against the fetch prediction. One cycle later it issues a
//               registered result and redirect, updates a 2-bit
//               saturating-counter branch history table (BHT), and counts
//               resolved and mispredicted branches. The BHT read port serves
//               fetch combinationally.
// Ports       : clk, resetn           - clock, async active-low reset
//               valid_i/stall_i/flush_i - E-stage handshake
//               cond_i, src_a_i, src_b_i - branch condition and operands
//               pc_i, target_i        - branch PC and computed taken target
//               pred_take_i, pred_target_i - fetch-stage prediction
//               fetch_pc_i / fetch_pred_o - BHT lookup for fetch
//               res_valid_o, actual_take_o, mispredict_o, redirect_pc_o
//                                     - registered resolution result
//               branch_cnt_o, mispred_cnt_o - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BHT_DEPTH  = 64,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [2:0]        cond_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              pred_take_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    output logic              fetch_pred_o,
    output logic              res_valid_o,
    output logic              actual_take_o,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    localparam int unsigned c_IDX_W = $clog2(BHT_DEPTH);

    // Fall-through skips the delay slot when the ISA has one.
    localparam logic [ADDR_W-1:0] c_FALL_OFS = (DELAY_SLOT != 0) ? ADDR_W'(8) : ADDR_W'(4);

    localparam logic [2:0] c_COND_NONE   = 3'b000;
    localparam logic [2:0] c_COND_EQ     = 3'b001;
    localparam logic [2:0] c_COND_NE     = 3'b010;
    localparam logic [2:0] c_COND_LEZ    = 3'b011;
    localparam logic [2:0] c_COND_GTZ    = 3'b100;
    localparam logic [2:0] c_COND_LTZ    = 3'b101;
    localparam logic [2:0] c_COND_GEZ    = 3'b110;
    localparam logic [2:0] c_COND_ALWAYS = 3'b111;

    // ------------------------------------------------------------------
    // E-stage combinational evaluation
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_take;
    logic              w_mispred;
    logic              w_a_neg;
    logic              w_a_zero;
    logic              w_a_eq_b;
    logic [ADDR_W-1:0] w_redirect;
    logic [c_IDX_W-1:0] w_pc_idx;
    logic [c_IDX_W-1:0] w_fetch_idx;
    logic              w_unused_fetch;

    assign w_accept  = valid_i & ~stall_i & ~flush_i & (cond_i != c_COND_NONE);
    assign w_a_neg   = src_a_i[DATA_W-1];
    assign w_a_zero  = (src_a_i == '0);
    assign w_a_eq_b  = (src_a_i == src_b_i);

    always_comb begin
        w_take = 1'b0;
        case (cond_i)
            c_COND_EQ:     w_take = w_a_eq_b;
            c_COND_NE:     w_take = ~w_a_eq_b;
            c_COND_GTZ:    w_take = ~w_a_neg & ~w_a_zero;
            c_COND_GEZ:    w_take = ~w_a_neg;
            c_COND_LTZ:    w_take = w_a_neg;
            c_COND_LEZ:    w_take = w_a_neg | w_a_zero;
            c_COND_ALWAYS: w_take = 1'b1;
            default:       w_take = 1'b0;
        endcase
    end

    // A correct direction with a wrong target still sends fetch astray.
    assign w_mispred  = (w_take != pred_take_i) |
                        (w_take & pred_take_i & (target_i != pred_target_i));
    assign w_redirect = w_take ? target_i : (pc_i + c_FALL_OFS);
    assign w_pc_idx   = pc_i[2 +: c_IDX_W];

    // Only the index bits of the fetch PC select a BHT entry.
    assign w_fetch_idx    = fetch_pc_i[2 +: c_IDX_W];
    assign w_unused_fetch = ^fetch_pc_i;

    // ------------------------------------------------------------------
    // Result registers and counters
    // ------------------------------------------------------------------
    logic               res_valid_q,   res_valid_d;
    logic               take_q,        take_d;
    logic               mispred_q,     mispred_d;
    logic [ADDR_W-1:0]  redirect_q,    redirect_d;
    logic [c_IDX_W-1:0] idx_q,         idx_d;
    logic               bht_upd_q,     bht_upd_d;
    logic [31:0]        branch_cnt_q,  branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        res_valid_d   = w_accept;
        take_d        = take_q;
        mispred_d     = mispred_q;
        redirect_d    = redirect_q;
        idx_d         = idx_q;
        bht_upd_d     = bht_upd_q;
        if (w_accept) begin
            take_d     = w_take;
            mispred_d  = w_mispred;
            redirect_d = w_redirect;
            idx_d      = w_pc_idx;
            // Unconditional jumps carry no direction information.
            bht_upd_d  = (cond_i != c_COND_ALWAYS);
        end

        // A registered result is always retired, regardless of stall/flush.
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res_valid_q) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (mispred_q) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid_q   <= 1'b0;
            take_q        <= 1'b0;
            mispred_q     <= 1'b0;
            redirect_q    <= '0;
            idx_q         <= '0;
            bht_upd_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_valid_q   <= res_valid_d;
            take_q        <= take_d;
            mispred_q     <= mispred_d;
            redirect_q    <= redirect_d;
            idx_q         <= idx_d;
            bht_upd_q     <= bht_upd_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Branch history table: 2-bit saturating counters, reset weakly
    // not-taken. The fetch read sees the pre-update value in the write
    // cycle because the entries are plain flops.
    // ------------------------------------------------------------------
    logic [1:0] bht_q [BHT_DEPTH];
    logic [1:0] w_bht_cur;
    logic [1:0] w_bht_nxt;
    logic       w_bht_we;

    assign w_bht_cur = bht_q[idx_q];
    assign w_bht_we  = res_valid_q & bht_upd_q;

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (take_q) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_nxt = w_bht_cur + 2'd1;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_nxt = w_bht_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            bht_q[idx_q] <= w_bht_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fetch_pred_o  = bht_q[w_fetch_idx][1];
    assign res_valid_o   = res_valid_q;
    assign actual_take_o = take_q;
    assign mispredict_o  = mispred_q;
    assign redirect_pc_o = redirect_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit with
//               default parameters (32-bit, 64-entry BHT, delay slot).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_i, stall_i, flush_i;
    logic [2:0]  cond_i;
    logic [31:0] src_a_i, src_b_i, pc_i, target_i, pred_target_i, fetch_pc_i;
    logic        pred_take_i;
    logic        fetch_pred_o, res_valid_o, actual_take_o, mispredict_o;
    logic [31:0] redirect_pc_o, branch_cnt_o, mispred_cnt_o;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .BHT_DEPTH  (64),
        .DELAY_SLOT (1)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .valid_i       (valid_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .cond_i        (cond_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .pc_i          (pc_i),
        .target_i      (target_i),
        .pred_take_i   (pred_take_i),
        .pred_target_i (pred_target_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_pred_o  (fetch_pred_o),
        .res_valid_o   (res_valid_o),
        .actual_take_o (actual_take_o),
        .mispredict_o  (mispredict_o),
        .redirect_pc_o (redirect_pc_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int unsigned exp_br = 0;
    int unsigned exp_mp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
        valid_i       = 1'b1;
        cond_i        = c;
        src_a_i       = a;
        src_b_i       = b;
        pc_i          = pc;
        target_i      = tgt;
        pred_take_i   = pt;
        pred_target_i = ptgt;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        cond_i  = 3'b000;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_brcnt"}, {32'b0, branch_cnt_o},  {32'b0, exp_br});
        check({tag, "_mpcnt"}, {32'b0, mispred_cnt_o}, {32'b0, exp_mp});
    endtask

    // Expected take per operand a (b = 5), bit (cond-1) for cond 1..7.
    logic [31:0] avals  [3];
    logic [6:0]  exp_tk [3];
    logic        tk;
    logic        fp_before [4];

    initial begin
        avals[0]  = 32'h8000_0000; exp_tk[0] = 7'b1010110;
        avals[1]  = 32'h0000_0000; exp_tk[1] = 7'b1100110;
        avals[2]  = 32'h0000_0005; exp_tk[2] = 7'b1101001;
        fp_before[0] = 1'b0; fp_before[1] = 1'b1; fp_before[2] = 1'b1; fp_before[3] = 1'b1;

        resetn = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        idle();
        src_a_i = '0; src_b_i = '0; pc_i = '0; target_i = '0;
        pred_take_i = 1'b0; pred_target_i = '0; fetch_pc_i = 32'h40;
        tick(); tick();
        resetn = 1'b1;
        tick();

        // ---------------- reset state
        check("rst_rv",    {63'b0, res_valid_o},   64'd0);
        check("rst_take",  {63'b0, actual_take_o}, 64'd0);
        check("rst_mp",    {63'b0, mispredict_o},  64'd0);
        check("rst_redir", {32'b0, redirect_pc_o}, 64'd0);
        check_cnts("rst");
        check("rst_fp",    {63'b0, fetch_pred_o},  64'd0);

        // ---------------- condition sweep (pc 0x800 -> BHT index 0)
        for (int i = 0; i < 3; i++) begin
            for (int c = 1; c <= 7; c++) begin
                drive(3'(c), avals[i], 32'd5, 32'h800, 32'h900, 1'b0, 32'h0);
                tick();
                idle();
                tk = exp_tk[i][c-1];
                check($sformatf("sweep_rv_a%0d_c%0d", i, c),   {63'b0, res_valid_o},   64'd1);
                check($sformatf("sweep_tk_a%0d_c%0d", i, c),   {63'b0, actual_take_o}, {63'b0, tk});
                check($sformatf("sweep_pc_a%0d_c%0d", i, c),   {32'b0, redirect_pc_o},
                      tk ? 64'h900 : 64'h808);
                exp_br++;
                if (tk) exp_mp++;
            end
        end
        tick();
        check_cnts("sweep");

        // ---------------- cond 000 is not a branch
        drive(3'b000, 32'd5, 32'd5, 32'h800, 32'h900, 1'b0, 32'h0);
        tick();
        idle();
        check("nobr_rv", {63'b0, res_valid_o}, 64'd0);
        tick();
        check_cnts("nobr");

        // ---------------- direction mispredicts
        drive(3'b001, 32'd7, 32'd7, 32'h1000, 32'h2000, 1'b0, 32'h0);
        tick();
        idle();
        check("mp_nt_take",  {63'b0, actual_take_o}, 64'd1);
        check("mp_nt_mp",    {63'b0, mispredict_o},  64'd1);
        check("mp_nt_redir", {32'b0, redirect_pc_o}, 64'h2000);
        exp_br++; exp_mp++;
        drive(3'b001, 32'd7, 32'd8, 32'h1000, 32'h2000, 1'b1, 32'h2000);
        tick();
        idle();
        check("mp_tk_take",  {63'b0, actual_take_o}, 64'd0);
        check("mp_tk_mp",    {63'b0, mispredict_o},  64'd1);
        check("mp_tk_redir", {32'b0, redirect_pc_o}, 64'h1008);
        exp_br++; exp_mp++;
        tick();
        check_cnts("mp");

        // ---------------- target mismatch, then a correct prediction
        drive(3'b111, 32'd0, 32'd0, 32'h1000, 32'h2000, 1'b1, 32'h2004);
        tick();
        idle();
        check("tgt_mp",    {63'b0, mispredict_o},  64'd1);
        check("tgt_redir", {32'b0, redirect_pc_o}, 64'h2000);
        exp_br++; exp_mp++;
        tick();
        check_cnts("tgt");
        drive(3'b111, 32'd0, 32'd0, 32'h1000, 32'h2000, 1'b1, 32'h2000);
        tick();
        idle();
        check("ok_mp", {63'b0, mispredict_o}, 64'd0);
        exp_br++;
        tick();
        check_cnts("ok");

        // ---------------- BHT saturation at pc 0x40 (index 16)
        fetch_pc_i = 32'h40;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bht_tk%0d_before", k), {63'b0, fetch_pred_o}, {63'b0, fp_before[k]});
            drive(3'b001, 32'd3, 32'd3, 32'h40, 32'h80, 1'b0, 32'h0);
            tick();
            idle();
            // Write cycle: read still returns the old counter.
            check($sformatf("bht_tk%0d_rdw", k), {63'b0, fetch_pred_o}, {63'b0, fp_before[k]});
            tick();
            check($sformatf("bht_tk%0d_after", k), {63'b0, fetch_pred_o}, 64'd1);
            exp_br++; exp_mp++;
        end
        fetch_pc_i = 32'h140;
        check("bht_alias_tk", {63'b0, fetch_pred_o}, 64'd1);
        drive(3'b001, 32'd3, 32'd4, 32'h40, 32'h80, 1'b0, 32'h0);
        tick(); idle(); tick();
        check("bht_nt1", {63'b0, fetch_pred_o}, 64'd1);
        exp_br++;
        drive(3'b001, 32'd3, 32'd4, 32'h40, 32'h80, 1'b0, 32'h0);
        tick(); idle(); tick();
        check("bht_nt2_alias", {63'b0, fetch_pred_o}, 64'd0);
        exp_br++;
        // Unconditional branch must leave the counter at 01.
        drive(3'b111, 32'd0, 32'd0, 32'h40, 32'h80, 1'b1, 32'h80);
        tick(); idle(); tick();
        fetch_pc_i = 32'h40;
        #1;
        check("bht_always_noupd", {63'b0, fetch_pred_o}, 64'd0);
        exp_br++;
        check_cnts("bht");

        // ---------------- stall holds off acceptance
        drive(3'b001, 32'd1, 32'd1, 32'h1000, 32'h2000, 1'b1, 32'h2000);
        stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall_rv%0d", s), {63'b0, res_valid_o}, 64'd0);
        end
        stall_i = 1'b0;
        tick();
        idle();
        check("stall_rel_rv", {63'b0, res_valid_o}, 64'd1);
        tick();
        check("stall_once_rv", {63'b0, res_valid_o}, 64'd0);
        exp_br++;
        check_cnts("stall");

        // stall arriving while a result is out: emitted and counted once
        drive(3'b001, 32'd1, 32'd1, 32'h1000, 32'h2000, 1'b1, 32'h2000);
        tick();
        check("stall_res_rv", {63'b0, res_valid_o}, 64'd1);
        stall_i = 1'b1;
        tick();
        check("stall_res_rv2", {63'b0, res_valid_o}, 64'd0);
        stall_i = 1'b0;
        idle();
        exp_br++;
        tick();
        check_cnts("stall_res");

        // ---------------- flush blocks acceptance
        drive(3'b001, 32'd1, 32'd1, 32'h1000, 32'h2000, 1'b0, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle();
        check("flush_rv", {63'b0, res_valid_o}, 64'd0);
        tick();
        check_cnts("flush");

        // flush does not cancel an already registered result
        drive(3'b001, 32'd1, 32'd1, 32'h1000, 32'h2000, 1'b0, 32'h0);
        tick();
        idle();
        check("flush_late_rv", {63'b0, res_valid_o}, 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        exp_br++; exp_mp++;
        check_cnts("flush_late");

        // ---------------- asynchronous reset mid-resolve
        drive(3'b001, 32'd2, 32'd2, 32'h40, 32'h80, 1'b0, 32'h0);
        tick();
        idle();
        #2;
        resetn = 1'b0;
        #1;
        check("arst_rv_now", {63'b0, res_valid_o}, 64'd0);
        exp_br = 0; exp_mp = 0;
        check_cnts("arst_now");
        tick();
        #2;
        resetn = 1'b1;
        tick();
        check("arst_rv",    {63'b0, res_valid_o},   64'd0);
        check("arst_take",  {63'b0, actual_take_o}, 64'd0);
        check("arst_redir", {32'b0, redirect_pc_o}, 64'd0);
        check_cnts("arst");
        fetch_pc_i = 32'h800;
        #1;
        check("arst_bht_idx0", {63'b0, fetch_pred_o}, 64'd0);
        fetch_pc_i = 32'h40;
        #1;
        check("arst_bht_idx16", {63'b0, fetch_pred_o}, 64'd0);
        // From 01, one taken update must flip the prediction.
        drive(3'b001, 32'd2, 32'd2, 32'h40, 32'h80, 1'b1, 32'h80);
        tick(); idle(); tick();
        check("arst_bht_weak", {63'b0, fetch_pred_o}, 64'd1);
        exp_br++;
        check_cnts("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
